// File: rtl/square_calc_pkg.sv
// Shared definitions for the calculator operation unit (square_root / square_calc).
package square_calc_pkg;

  // Default operand/result width for the calculator datapath.
  localparam int unsigned DefaultWidth = 28;

  // Operation FSM states shared by the iterative units.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StCalc = 1'b1
  } calc_state_e;

endpackage

// File: rtl/square_calc.sv
// Iterative shift-and-add squarer: one signed operand in, non-negative signed square out.
// Operands with |x| >= 2^(N/2) are rejected in one cycle; products above the largest
// positive N-bit value are flagged after the N/2 iterations. eroare is sticky until the
// next accepted operand.
module square_calc
  import square_calc_pkg::*;
#(
  parameter int unsigned N = DefaultWidth
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [N-1:0] num_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         eroare
);

  localparam int unsigned Half = N / 2;
  localparam int unsigned CntW = $clog2(Half) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Half - 1);

  calc_state_e state_q, state_d;

  logic [N-1:0]    acc_q, acc_d;
  logic [Half-1:0] mplier_q, mplier_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    result_q, result_d;
  logic            done_q, done_d;
  logic            eroare_q, eroare_d;

  logic [N-1:0] mag;
  logic         in_range;
  logic [N-1:0] acc_sum;
  logic         last_iter;

  // Operand magnitude; -2^(N-1) negates to itself and is caught by the range check.
  always_comb begin
    mag       = num_in[N-1] ? -num_in : num_in;
    in_range  = (mag[N-1:Half] == '0);
    acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    last_iter = (cnt_q == LastCnt);
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      eroare_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      eroare_q <= eroare_d;
    end
  end

  // Next-state logic: accept in idle, leave calc after the final iteration.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (valid_in && in_range) state_d = StCalc;
      StCalc: if (last_iter) state_d = StIdle;
    endcase
  end

  // Datapath next-state: operand capture, one multiply step per cycle, result/flag update.
  always_comb begin
    acc_d    = acc_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    eroare_d = eroare_q;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          eroare_d = 1'b0;
          if (!in_range) begin
            result_d = '0;
            eroare_d = 1'b1;
            done_d   = 1'b1;
          end else begin
            acc_d    = '0;
            cnt_d    = '0;
            mplier_d = mag[Half-1:0];
            mcand_d  = {{(N - Half){1'b0}}, mag[Half-1:0]};
          end
        end
      end
      StCalc: begin
        acc_d    = acc_sum;
        mplier_d = mplier_q >> 1;
        mcand_d  = mcand_q << 1;
        cnt_d    = cnt_q + CntW'(1);
        if (last_iter) begin
          done_d = 1'b1;
          // Product is below 2^N, so the top bit alone marks a non-representable result.
          if (acc_sum[N-1]) begin
            result_d = '0;
            eroare_d = 1'b1;
          end else begin
            result_d = acc_sum;
          end
        end
      end
    endcase
  end

  // Outputs: busy follows the state, the rest come straight from registers.
  always_comb begin
    busy   = (state_q == StCalc);
    done   = done_q;
    result = result_q;
    eroare = eroare_q;
  end

endmodule

// File: tb/tb_square_calc.sv
// Self-checking bench for square_calc (N=28): directed cases plus randomized operands,
// each compared against an arithmetic reference model.
module tb_square_calc;

  localparam int unsigned N = 28;

  logic         clk;
  logic         rst;
  logic         valid_in;
  logic [N-1:0] num_in;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         eroare;

  int vectors;
  int miscompares;
  logic [N-1:0] prev_result;

  square_calc #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .num_in   (num_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .eroare   (eroare)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer square with the two overflow rules.
  task automatic model(input logic [N-1:0] x, output bit range_err, output bit err,
                       output longint res);
    longint sx, m, sq;
    sx = longint'(signed'(x));
    m  = (sx < 0) ? -sx : sx;
    range_err = (m >= (64'sd1 << (N / 2)));
    if (range_err) begin
      err = 1'b1;
      res = 0;
    end else begin
      sq = m * m;
      err = (sq > ((64'sd1 << (N - 1)) - 1));
      res = err ? 0 : sq;
    end
  endtask

  // Present an operand for one edge; with hold, valid_in stays high and num_in is scrambled.
  task automatic drive_and_step(input logic [N-1:0] x, input bit hold);
    valid_in = 1'b1;
    num_in   = x;
    @(negedge clk);
    if (hold) num_in = N'($urandom);
    else valid_in = 1'b0;
  endtask

  // Called at the negedge right after the accepting edge; waits for done and checks it.
  task automatic expect_op(input string tag, input logic [N-1:0] x, input bit hold);
    bit range_err, err;
    longint res;
    int lat, busy_n;
    model(x, range_err, err, res);
    if (!range_err) begin
      chk({tag, ".eroare_at_accept"}, longint'(eroare), 0);
      chk({tag, ".result_held"}, longint'(result), longint'(prev_result));
    end
    lat = 0;
    busy_n = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_n++;
      if (hold) num_in = N'($urandom);
      @(negedge clk);
      lat++;
    end
    chk({tag, ".done_seen"}, longint'(done), 1);
    // Edges after the accepting one until done: 0 for a rejected operand, N/2 otherwise.
    chk({tag, ".latency"}, lat, range_err ? 0 : N / 2);
    chk({tag, ".busy_cycles"}, busy_n, range_err ? 0 : N / 2);
    chk({tag, ".busy_at_done"}, longint'(busy), 0);
    chk({tag, ".result"}, longint'(result), res);
    chk({tag, ".eroare"}, longint'(eroare), longint'(err));
    prev_result = N'(res);
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] x);
    @(negedge clk);
    drive_and_step(x, 1'b0);
    expect_op(tag, x, 1'b0);
  endtask

  initial begin
    logic [N-1:0] a, b, x;
    bit done_after;
    vectors     = 0;
    miscompares = 0;
    prev_result = '0;
    rst      = 1'b0;
    valid_in = 1'b0;
    num_in   = '0;
    #1;
    chk("reset.busy", longint'(busy), 0);
    chk("reset.done", longint'(done), 0);
    chk("reset.result", longint'(result), 0);
    chk("reset.eroare", longint'(eroare), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    run_op("sq5", N'(5));
    run_op("sqm12", N'(-12));
    run_op("sq0", N'(0));
    run_op("sq11585", N'(11585));
    run_op("sq11586", N'(11586));
    run_op("sq16384", N'(16384));
    x = '0;
    x[N-1] = 1'b1;
    run_op("sqmin", x);
    run_op("sq3", N'(3));
    run_op("sqm16383", N'(-16383));

    // valid_in held through CALC: only the first operand counts, then re-accept on done.
    @(negedge clk);
    drive_and_step(N'(9), 1'b1);
    expect_op("hold_first", N'(9), 1'b1);
    drive_and_step(N'(-13), 1'b0);
    expect_op("hold_second", N'(-13), 1'b0);

    // valid_in held into a rejected operand, then back-to-back into a normal one.
    @(negedge clk);
    drive_and_step(N'(20000), 1'b1);
    expect_op("b2b_reject", N'(20000), 1'b1);
    drive_and_step(N'(6), 1'b0);
    expect_op("b2b_after", N'(6), 1'b0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    drive_and_step(N'(100), 1'b0);
    repeat (6) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst.busy", longint'(busy), 0);
    chk("midrst.done", longint'(done), 0);
    chk("midrst.result", longint'(result), 0);
    chk("midrst.eroare", longint'(eroare), 0);
    prev_result = '0;
    @(negedge clk);
    rst = 1'b1;
    // Nothing from the lost operation may surface after release.
    done_after = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (done === 1'b1) done_after = 1'b1;
    end
    chk("midrst.no_stale_done", longint'(done_after), 0);
    run_op("after_rst7", N'(7));

    // Randomized operands across in-range, near-boundary and out-of-range values.
    for (int i = 0; i < 24; i++) begin
      unique case (i % 4)
        0: x = N'($urandom_range(0, 16383));
        1: x = -N'($urandom_range(0, 16383));
        2: x = N'(11580 + $urandom_range(0, 10));
        default: x = N'($urandom);
      endcase
      run_op($sformatf("rnd%0d", i), x);
    end

    // Randomized back-to-back pairs.
    for (int i = 0; i < 4; i++) begin
      a = N'($urandom_range(0, 16383));
      b = -N'($urandom_range(0, 12000));
      @(negedge clk);
      drive_and_step(a, 1'b1);
      expect_op($sformatf("rb2b%0d_a", i), a, 1'b1);
      drive_and_step(b, 1'b0);
      expect_op($sformatf("rb2b%0d_b", i), b, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
